// File: rtl/button_debouncer.sv
// button_debouncer: 14 independent synchronize-and-debounce channels for board KEY/SW pins.
// Define BUTTON_DEBOUNCER_RELEASE_EN to build the pb_released pulse logic.

module button_debouncer_lane #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic SI_ClkIn,
    input  logic SI_Reset_N,
    input  logic raw,
    input  logic level,
    output logic level_next
);
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   differ;
    logic                   expired;

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) sync <= '0;
        else             sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    assign differ     = sync[SYNC_STAGES-1] ^ level;
    assign expired    = differ && (cnt == CNT_MAX);
    assign level_next = level ^ expired;

    // Any cycle of agreement restarts the count, so only an unbroken run toggles.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N)           cnt <= '0;
        else if (!differ || expired) cnt <= '0;
        else                       cnt <= cnt + CNT_W'(1);
    end
endmodule

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       SI_ClkIn,
    input  logic       SI_Reset_N,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [3:0] pb_level,
    output logic [3:0] pb_pressed,
    output logic [3:0] pb_released,
    output logic [9:0] sw_level
);
    localparam int NUM_CH = 14;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] level_next;

    // Buttons are active-low on the board; flip them so every lane is active-high.
    assign raw = {SW, ~KEY};

    // Level flops live here so edge pulses can be formed from next-state and
    // land on the same edge as the level update.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        button_debouncer_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_lane (
            .SI_ClkIn  (SI_ClkIn),
            .SI_Reset_N(SI_Reset_N),
            .raw       (raw[i]),
            .level     (level[i]),
            .level_next(level_next[i])
        );
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) level <= '0;
        else             level <= level_next;
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) pb_pressed <= '0;
        else             pb_pressed <= level_next[3:0] & ~level[3:0];
    end

`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) pb_released <= '0;
        else             pb_released <= ~level_next[3:0] & level[3:0];
    end
`else
    assign pb_released = '0;
`endif

    assign pb_level = level[3:0];
    assign sw_level = level[13:4];
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (6-cycle latency).

module tb_button_debouncer;
    localparam int DC = 4;
    localparam int SS = 2;

`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    localparam logic [3:0] REL_BOTH = 4'b1001;
`else
    localparam logic [3:0] REL_BOTH = 4'b0000;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key   = 4'hF;
    logic [9:0] sw    = '0;
    logic [3:0] pb_level, pb_pressed, pb_released;
    logic [9:0] sw_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SS)
    ) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .KEY        (key),
        .SW         (sw),
        .pb_level   (pb_level),
        .pb_pressed (pb_pressed),
        .pb_released(pb_released),
        .sw_level   (sw_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key   = 4'hF;
        sw    = '0;
        repeat (3) tick();
        checks++;
        if ({pb_level, pb_pressed, pb_released, sw_level} !== 22'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", {pb_level, pb_pressed, pb_released, sw_level});
        end
        rst_n = 1'b1;
        repeat (8) tick();
        checks++;
        if ({pb_level, pb_pressed, pb_released, sw_level} !== 22'd0) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=0", {pb_level, pb_pressed, pb_released, sw_level});
        end
    endtask

    task automatic test_press();
        logic [3:0] exp_lvl, exp_prs;
        key = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lvl = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_prs = (k == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (pb_level !== exp_lvl || pb_pressed !== exp_prs || pb_released !== 4'b0000) begin
                failures++;
                $display("FAIL press k=%0d lvl=%b/%b prs=%b/%b rel=%b/0000",
                         k, pb_level, exp_lvl, pb_pressed, exp_prs, pb_released);
            end
        end
    endtask

    task automatic test_glitch();
        key = 4'b1100;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) key = 4'b1110;
            checks++;
            if (pb_level !== 4'b0001 || pb_pressed !== 4'b0000) begin
                failures++;
                $display("FAIL glitch k=%0d lvl=%b/0001 prs=%b/0000", k, pb_level, pb_pressed);
            end
        end
    endtask

    task automatic test_bounce();
        logic       pat [5];
        logic [9:0] exp_sw;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            sw[9] = pat[i];
            tick();
            checks++;
            if (sw_level !== 10'h000) begin
                failures++;
                $display("FAIL bounce_early i=%0d got=%h exp=000", i, sw_level);
            end
        end
        sw[9] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_sw = (k >= 6) ? 10'h200 : 10'h000;
            checks++;
            if (sw_level !== exp_sw) begin
                failures++;
                $display("FAIL bounce_settle k=%0d got=%h exp=%h", k, sw_level, exp_sw);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_lvl, exp_prs, exp_rel;
        key = 4'b0110;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lvl = (k >= 6) ? 4'b1001 : 4'b0001;
            exp_prs = (k == 6) ? 4'b1000 : 4'b0000;
            checks++;
            if (pb_level !== exp_lvl || pb_pressed !== exp_prs) begin
                failures++;
                $display("FAIL press3 k=%0d lvl=%b/%b prs=%b/%b", k, pb_level, exp_lvl, pb_pressed, exp_prs);
            end
        end
        key = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lvl = (k >= 6) ? 4'b0000 : 4'b1001;
            exp_rel = (k == 6) ? REL_BOTH : 4'b0000;
            checks++;
            if (pb_level !== exp_lvl || pb_released !== exp_rel || pb_pressed !== 4'b0000) begin
                failures++;
                $display("FAIL release k=%0d lvl=%b/%b rel=%b/%b prs=%b/0000",
                         k, pb_level, exp_lvl, pb_released, exp_rel, pb_pressed);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_lvl, exp_prs;
        logic [9:0] exp_sw;
        key = 4'b1011;
        repeat (4) tick();
        checks++;
        if (sw_level !== 10'h200 || pb_level !== 4'b0000) begin
            failures++;
            $display("FAIL pre_reset sw=%h/200 lvl=%b/0000", sw_level, pb_level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pb_level, pb_pressed, pb_released, sw_level} !== 22'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {pb_level, pb_pressed, pb_released, sw_level});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lvl = (k >= 6) ? 4'b0100 : 4'b0000;
            exp_prs = (k == 6) ? 4'b0100 : 4'b0000;
            exp_sw  = (k >= 6) ? 10'h200 : 10'h000;
            checks++;
            if (pb_level !== exp_lvl || pb_pressed !== exp_prs || sw_level !== exp_sw) begin
                failures++;
                $display("FAIL post_reset k=%0d lvl=%b/%b prs=%b/%b sw=%h/%h",
                         k, pb_level, exp_lvl, pb_pressed, exp_prs, sw_level, exp_sw);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles before a debounced level change (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth per input; legal range 2..4.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: SI_ClkIn is the sole clock (rising edge), SI_Reset_N is the reset, asserted when low.
REQ-004 SI_ClkIn  input  1  system clock.
REQ-005 SI_Reset_N  input  1  asynchronous active-low reset.
REQ-006 KEY  input  4  raw board pushbuttons, active-low, asynchronous to SI_ClkIn.
REQ-007 SW  input  10  raw board slide switches, active-high, asynchronous to SI_ClkIn.
REQ-008 pb_level  output  4  debounced pushbutton state, active-high (1 = pressed); drives IO_PB[3:0] of mipsfpga_sys.
REQ-009 pb_pressed  output  4  one-cycle pulse per button on debounced press.
REQ-010 pb_released  output  4  one-cycle pulse per button on debounced release (see Configuration).
REQ-011 sw_level  output  10  debounced switch state; drives IO_Switch[9:0] of mipsfpga_sys.

Function
REQ-012 Each of the 14 channels SHALL be independent: SYNC_STAGES-flop synchronizer, counter, registered level.
REQ-013 KEY SHALL be inverted before synchronization so all internal channels are active-high.
REQ-014 Per channel, each cycle the synchronized input differs from the level register, the counter SHALL increment by 1.
REQ-015 Any cycle the synchronized input equals the level register, the counter SHALL clear to 0 (glitch rejection).
REQ-016 The counter SHALL be wide enough for DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 When the counter equals DEBOUNCE_CYCLES-1 and the input still differs, the level SHALL toggle on that edge and the counter SHALL clear.
REQ-018 Raw-pin-to-level latency SHALL be SYNC_STAGES + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-019 pb_pressed[i] SHALL be high for exactly the one cycle following the pb_level[i] 0->1 update, registered and aligned with the new level.
REQ-020 pb_released[i] SHALL behave like pb_pressed[i] for 1->0 updates.
REQ-021 Simultaneous transitions on several channels SHALL each produce their own level change and pulse in the same cycle.
REQ-022 An input pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-023 The outputs SHALL be driven only from flops; no combinational path from KEY/SW to any output.

Reset
REQ-024 While SI_Reset_N is low, synchronizer flops, counters, pb_level, pb_pressed, pb_released and sw_level SHALL all be 0.
REQ-025 Reset mid-count SHALL discard partial counts; no pulse SHALL occur in the cycle reset deasserts.
REQ-026 After reset release, a switch already up SHALL reach sw_level=1 after SYNC_STAGES+DEBOUNCE_CYCLES cycles; a button held through reset SHALL then yield one pb_pressed pulse.

Configuration
REQ-027 Macro BUTTON_DEBOUNCER_RELEASE_EN SHALL control release detection.
REQ-028 With BUTTON_DEBOUNCER_RELEASE_EN defined, pb_released SHALL behave per REQ-020.
REQ-029 Without it, pb_released SHALL be constant 0 and its logic SHALL not be synthesized; all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 Reset, then KEY=4'b1110 steady from cycle 0 -> pb_level=4'b0001 from cycle 6, pb_pressed=4'b0001 for cycle 6 only.
REQ-031 KEY[1] low for 3 cycles, then high -> pb_level and pb_pressed stay 0.
REQ-032 SW[9] bounces 1,0,1,1,0 then holds 1 -> sw_level[9] rises exactly 6 cycles after the final 0->1 raw edge.
REQ-033 KEY[0] and KEY[3] released in the same cycle after a debounced press -> pb_level bits clear in the same cycle; with macro, pb_released=4'b1001 for one cycle; without macro, pb_released stays 0.
REQ-034 SI_Reset_N pulsed low while KEY[2] held low with counter at 2 -> all outputs 0 asynchronously; after release, pb_pressed[2] pulses once 6 cycles later.
